// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - Default geometry (DEPTH words of DW bits, AW-bit word addresses).
//   - Host command encodings (LOAD / DUMP).
//   - Load/dump engine state encoding.
package dmem_pkg;

  localparam int DMEM_DEPTH = 128;
  localparam int DMEM_AW    = 7;
  localparam int DMEM_DW    = 32;

  localparam logic DMEM_CMD_LOAD = 1'b0;
  localparam logic DMEM_CMD_DUMP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_FIN  = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DW storage with asynchronous clear.
// Ports:
//   clk, rst_n            clock (posedge), async active-low clear of every word
//   we_i, waddr_i, wdata_i single write port, committed at posedge
//   raddrA_i / rdataA_o   async read port (core address)
//   raddrB_i / rdataB_o   async read port (host pointer)
// Reads are combinational, so a read in the same cycle as a write to the
// same word returns the old contents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW,
  parameter int DW    = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddrA_i,
  output logic [DW-1:0] rdataA_o,
  input  logic [AW-1:0] raddrB_i,
  output logic [DW-1:0] rdataB_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdataA_o = mem_q[raddrA_i];
  assign rdataB_o = mem_q[raddrB_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: SRAM-side responder for the single-cycle MIPS core, plus a
// host load/dump engine used to preload memory and read results back.
// Ports:
//   clk, rst_n                      clock (posedge), async active-low reset
//   CEN, WEN, OEN, A, D, Q          core SRAM interface (active-low enables,
//                                   WEN=0 write), Q is zero-latency read data
//   hst_cmd_valid/ready, hst_cmd,   host command: LOAD/DUMP of hst_len words
//   hst_base, hst_len               starting at hst_base (wrapping mod DEPTH)
//   hst_wvalid/wready, hst_wdata    LOAD data stream
//   hst_rvalid/rready, hst_rdata    DUMP data stream
//   busy, done                      engine not idle / one-cycle completion
// The core always has priority: a host LOAD beat is refused in any cycle the
// core writes, so the core never stalls.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW,
  parameter int DW    = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  input  logic          hst_cmd_valid,
  output logic          hst_cmd_ready,
  input  logic          hst_cmd,
  input  logic [AW-1:0] hst_base,
  input  logic [AW:0]   hst_len,
  input  logic          hst_wvalid,
  output logic          hst_wready,
  input  logic [DW-1:0] hst_wdata,
  output logic          hst_rvalid,
  input  logic          hst_rready,
  output logic [DW-1:0] hst_rdata,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [AW:0]   CntOne = (AW + 1)'(1);

  dmem_state_e   state_q;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   len_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   fetchCnt_q;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;

  logic          coreWr;
  logic          hostBeat;
  logic          handshake;
  logic          fetch;
  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] coreRdata;
  logic [DW-1:0] hostRdata;

  assign coreWr    = ~CEN & ~WEN;
  assign hst_wready = (state_q == ST_LOAD) & ~coreWr;
  assign hostBeat  = hst_wvalid & hst_wready;
  assign handshake = (state_q == ST_DUMP) & rvalid_q & hst_rready;
  // A fetch refills the holding register when it is empty or being drained
  // this cycle, until every requested word has been fetched.
  assign fetch     = (state_q == ST_DUMP) & (~rvalid_q | hst_rready)
                     & (fetchCnt_q != len_q);

  // Core and host writes are mutually exclusive by construction of hst_wready.
  always_comb begin
    memWe    = 1'b0;
    memWaddr = A;
    memWdata = D;
    if (coreWr) begin
      memWe = 1'b1;
    end else if (hostBeat) begin
      memWe    = 1'b1;
      memWaddr = ptr_q;
      memWdata = hst_wdata;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (memWe),
    .waddr_i (memWaddr),
    .wdata_i (memWdata),
    .raddrA_i(A),
    .rdataA_o(coreRdata),
    .raddrB_i(ptr_q),
    .rdataB_o(hostRdata)
  );

  assign Q             = (~CEN & ~OEN) ? coreRdata : '0;
  assign hst_cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FIN);
  assign hst_rvalid    = rvalid_q;
  assign hst_rdata     = rdata_q;

  // ptr_q wraps naturally at DEPTH because it is exactly AW bits wide.
  // cnt_q counts completed beats (LOAD) or handshakes (DUMP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      fetchCnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hst_cmd_valid) begin
            ptr_q      <= hst_base;
            len_q      <= hst_len;
            cnt_q      <= '0;
            fetchCnt_q <= '0;
            if (hst_len == '0) begin
              state_q <= ST_FIN;
            end else if (hst_cmd == DMEM_CMD_DUMP) begin
              state_q <= ST_DUMP;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (hostBeat) begin
            ptr_q <= ptr_q + PtrOne;
            cnt_q <= cnt_q + CntOne;
            if (cnt_q + CntOne == len_q) begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_DUMP: begin
          if (fetch) begin
            rdata_q    <= hostRdata;
            rvalid_q   <= 1'b1;
            ptr_q      <= ptr_q + PtrOne;
            fetchCnt_q <= fetchCnt_q + CntOne;
          end else if (handshake) begin
            rvalid_q <= 1'b0;
          end
          if (handshake) begin
            cnt_q <= cnt_q + CntOne;
            if (cnt_q + CntOne == len_q) begin
              rvalid_q <= 1'b0;
              state_q  <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
